// File: rtl/usb_tx_line.sv
// usb_tx_line: USB host transmit line stage.
// Inserts stuff bits after runs of ones, NRZI-encodes onto DP/DM, closes each
// packet with SE0/J EOP and throttles the upstream serializer via pause.
// Build option: define USB_TX_BITSTUFF_EN to enable bit stuffing (STUFF state,
// ones counter and the STUFF_RUN parameter). Default build sends runs of ones
// unmodified, for debug of upstream framing.
module usb_tx_line #(
  parameter int unsigned EOP_SE0_CYCLES = 2,
  parameter int unsigned EOP_J_CYCLES   = 1
`ifdef USB_TX_BITSTUFF_EN
  ,
  parameter int unsigned STUFF_RUN      = 6
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic pkt_end,
  output logic pause,
  output logic busy,
  output logic dp,
  output logic dm,
  output logic line_oe
);

  localparam int unsigned EOP_MAX = (EOP_SE0_CYCLES > EOP_J_CYCLES) ? EOP_SE0_CYCLES
                                                                     : EOP_J_CYCLES;
  localparam int unsigned EOP_W   = (EOP_MAX > 0) ? $clog2(EOP_MAX + 1) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
`ifdef USB_TX_BITSTUFF_EN
  localparam logic [2:0] ST_STUFF   = 3'd2;
`endif
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             lvl_q, lvl_d;      // NRZI line level, 1 = J
  logic             dp_q, dp_d;
  logic             dm_q, dm_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic [EOP_W-1:0] eop_q, eop_d;
  logic             base_lvl;
  logic             enc_lvl;

`ifdef USB_TX_BITSTUFF_EN
  localparam int unsigned ONES_W = $clog2(STUFF_RUN + 1);

  logic [ONES_W-1:0] ones_q, ones_d;
  logic [ONES_W-1:0] ones_inc;
  logic              stend_q, stend_d; // stuff-triggering bit carried pkt_end

  assign ones_inc = bit_in ? (ones_q + ONES_W'(1)) : '0;
  assign pause    = (state_q == ST_STUFF) || (state_q == ST_EOP_SE0) ||
                    (state_q == ST_EOP_J);
`else
  assign pause    = (state_q == ST_EOP_SE0) || (state_q == ST_EOP_J);
`endif

  // Every packet encodes relative to J, whatever the level register holds.
  assign base_lvl = (state_q == ST_IDLE) ? 1'b1 : lvl_q;
  assign enc_lvl  = bit_in ? base_lvl : ~base_lvl;

  assign dp      = dp_q;
  assign dm      = dm_q;
  assign line_oe = oe_q;
  assign busy    = busy_q;

  // Next-state logic: bit acceptance, stuff insertion and EOP sequencing.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    eop_d   = eop_q;
`ifdef USB_TX_BITSTUFF_EN
    ones_d  = ones_q;
    stend_d = stend_q;
`endif
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (state_q == ST_IDLE) begin
          lvl_d  = 1'b1;
          dp_d   = 1'b1;
          dm_d   = 1'b0;
          oe_d   = 1'b0;
          busy_d = 1'b0;
        end
        if (bit_valid) begin
          lvl_d   = enc_lvl;
          dp_d    = enc_lvl;
          dm_d    = ~enc_lvl;
          oe_d    = 1'b1;
          busy_d  = 1'b1;
          eop_d   = '0;
          state_d = pkt_end ? ST_EOP_SE0 : ST_DATA;
`ifdef USB_TX_BITSTUFF_EN
          // A completed run always detours through STUFF; pkt_end is
          // remembered so the EOP follows the stuff bit.
          ones_d = ones_inc;
          if (ones_inc == ONES_W'(STUFF_RUN)) begin
            state_d = ST_STUFF;
            stend_d = pkt_end;
          end
`endif
        end
      end
`ifdef USB_TX_BITSTUFF_EN
      ST_STUFF: begin
        lvl_d   = ~lvl_q;
        dp_d    = ~lvl_q;
        dm_d    = lvl_q;
        ones_d  = '0;
        stend_d = 1'b0;
        eop_d   = '0;
        state_d = stend_q ? ST_EOP_SE0 : ST_DATA;
      end
`endif
      ST_EOP_SE0: begin
        dp_d = 1'b0;
        dm_d = 1'b0;
        oe_d = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
        ones_d = '0;
`endif
        if (eop_q == EOP_W'(EOP_SE0_CYCLES - 1)) begin
          eop_d   = '0;
          state_d = ST_EOP_J;
        end else begin
          eop_d = eop_q + EOP_W'(1);
        end
      end
      ST_EOP_J: begin
        lvl_d = 1'b1;
        dp_d  = 1'b1;
        dm_d  = 1'b0;
        oe_d  = 1'b1;
`ifdef USB_TX_BITSTUFF_EN
        ones_d = '0;
`endif
        if (eop_q == EOP_W'(EOP_J_CYCLES - 1)) begin
          eop_d   = '0;
          state_d = ST_IDLE;
        end else begin
          eop_d = eop_q + EOP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered line outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lvl_q   <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      eop_q   <= '0;
`ifdef USB_TX_BITSTUFF_EN
      ones_q  <= '0;
      stend_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      eop_q   <= eop_d;
`ifdef USB_TX_BITSTUFF_EN
      ones_q  <= ones_d;
      stend_q <= stend_d;
`endif
    end
  end

endmodule

// File: tb/tb_usb_tx_line.sv
// tb_usb_tx_line: randomized bench for usb_tx_line. A packet-level reference
// model expands each packet into a per-cycle list of driven inputs and the
// expected line, line_oe, busy and pause seen during that cycle.
module tb_usb_tx_line;

  localparam int unsigned SE0N = 2;
  localparam int unsigned JN   = 1;
  localparam int          RUN  = 6;
`ifdef USB_TX_BITSTUFF_EN
  localparam bit STUFF_ON = 1'b1;
`else
  localparam bit STUFF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic pkt_end = 1'b0;
  logic pause, busy, dp, dm, line_oe;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  usb_tx_line #(
    .EOP_SE0_CYCLES(SE0N),
    .EOP_J_CYCLES  (JN)
`ifdef USB_TX_BITSTUFF_EN
    ,
    .STUFF_RUN     (RUN)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .pkt_end  (pkt_end),
    .pause    (pause),
    .busy     (busy),
    .dp       (dp),
    .dm       (dm),
    .line_oe  (line_oe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic r, v, b, e, p;          // inputs for the cycle and expected pause
    logic xdp, xdm, xoe, xbusy;   // expected registered outputs in the cycle
  } cyc_t;

  cyc_t q[$];
  logic cur_dp, cur_dm, cur_oe, cur_busy;
  logic pb[32];
  int   pg[32];

  task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // Append one cycle: outputs seen now are the current ones; the edge at the
  // end of the cycle makes the n* values current.
  task automatic push(input logic r, input logic v, input logic b, input logic e,
                      input logic p, input logic ndp, input logic ndm,
                      input logic noe, input logic nbusy);
    cyc_t c;
    c.r = r; c.v = v; c.b = b; c.e = e; c.p = p;
    c.xdp = cur_dp; c.xdm = cur_dm; c.xoe = cur_oe; c.xbusy = cur_busy;
    q.push_back(c);
    cur_dp = ndp; cur_dm = ndm; cur_oe = noe; cur_busy = nbusy;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      push(1'b0, 1'b0, rnd(), rnd(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // One packet of n bits from pb/pg; abort_at >= 0 resets after that bit.
  task automatic gen_pkt(input int n, input int abort_at);
    logic lvl;
    logic last;
    int   run;
    lvl = 1'b1;
    run = 0;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      for (int g = 0; g < pg[i]; g++) begin
        if (i == 0) push(1'b0, 1'b0, rnd(), rnd(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        else        push(1'b0, 1'b0, rnd(), rnd(), 1'b0, cur_dp, cur_dm, cur_oe, cur_busy);
      end
      if (!pb[i]) lvl = ~lvl;
      push(1'b0, 1'b1, pb[i], last, 1'b0, lvl, ~lvl, 1'b1, 1'b1);
      run = pb[i] ? run + 1 : 0;
      if (STUFF_ON && run == RUN) begin
        lvl = ~lvl;
        run = 0;
        if (!last && pg[i+1] == 0)
          push(1'b0, 1'b1, pb[i+1], (i + 1 == n - 1), 1'b1, lvl, ~lvl, 1'b1, 1'b1);
        else
          push(1'b0, 1'b0, rnd(), rnd(), 1'b1, lvl, ~lvl, 1'b1, 1'b1);
      end
      if (i == abort_at && !last) begin
        push(1'b1, 1'b0, rnd(), rnd(), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    for (int i = 0; i < int'(SE0N); i++)
      push(1'b0, rnd(), rnd(), rnd(), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < int'(JN); i++)
      push(1'b0, rnd(), rnd(), rnd(), 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic set_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      pb[i] = v[i];
      pg[i] = 0;
    end
  endtask

  task automatic check_cycle(input cyc_t c);
    check_val("line",  {dp, dm},        {c.xdp, c.xdm});
    check_val("oe",    {1'b0, line_oe}, {1'b0, c.xoe});
    check_val("busy",  {1'b0, busy},    {1'b0, c.xbusy});
    check_val("pause", {1'b0, pause},   {1'b0, c.p});
  endtask

  initial begin
    int n;
    int ab;
    cyc_t fin;
    cur_dp = 1'b1; cur_dm = 1'b0; cur_oe = 1'b0; cur_busy = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_line",  {dp, dm},        2'b10);
    check_val("rst_oe",    {1'b0, line_oe}, 2'b00);
    check_val("rst_pause", {1'b0, pause},   2'b00);
    check_val("rst_busy",  {1'b0, busy},    2'b00);
    rst = 1'b0;

    // SYNC then OUT PID 0xE1, LSB-first
    set_bits(32'h0000_E180, 16); gen_pkt(16, -1); idle(2);
    // 0 then seven 1s: one stuff bit in the run
    set_bits(32'h0000_00FE, 8);  gen_pkt(8, -1);
    // back-to-back: six 1s ending the packet, stuff before EOP
    set_bits(32'h0000_003F, 6);  gen_pkt(6, -1); idle(1);
    // 0 then eight 1s
    set_bits(32'h0000_01FE, 9);  gen_pkt(9, -1); idle(1);
    // reset during DATA
    set_bits(32'h0000_001A, 5);  gen_pkt(5, 2); idle(1);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        pb[i] = ($urandom_range(0, 3) != 0);
        pg[i] = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
      end
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      gen_pkt(n, ab);
      idle($urandom_range(0, 2));
    end

    for (int c = 0; c < q.size(); c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cyc = c;
      check_cycle(q[c]);
      rst       = q[c].r;
      bit_valid = q[c].v;
      bit_in    = q[c].b;
      pkt_end   = q[c].e;
    end
    @(posedge clk);
    #1;
    cyc = q.size();
    fin = '0;
    fin.xdp = cur_dp; fin.xdm = cur_dm; fin.xoe = cur_oe; fin.xbusy = cur_busy;
    check_cycle(fin);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
